// File: rtl/iso7816_3_tpdu_tracker.sv
// Passive ISO 7816-3 T=0 byte-stream tracker: follows ATR, PPS and TPDU exchanges
// from received bytes and reports negotiated parameters, expected sender and status.
//
// state    | meaning
// ---------+----------------------------------------------------
// ATR_TS   | waiting for TS
// ATR_T0   | waiting for T0 (K and first interface mask)
// ATR_IF   | consuming TAi/TBi/TCi/TDi interface bytes
// ATR_HIST | consuming K historical bytes
// ATR_TCK  | waiting for TCK
// IDLE     | between exchanges, next byte is PPSS or CLA
// PPS_REQ  | terminal PPS request
// PPS_RSP  | card PPS response
// HDR      | INS, P1, P2, P3 of a command header
// PB       | waiting for procedure byte
// DATA     | data transfer after ACK (remaining count bytes)
// NACK     | single data byte after ~INS
// SW2      | waiting for SW2
module iso7816_3_tpdu_tracker #(
   parameter int BYTES_CNT_WIDTH = 32,
   parameter bit P3_ZERO_IS_256  = 1'b1,
   parameter bit CHECK_TCK       = 1'b1
) (
   input  logic                       clk,
   input  logic                       nReset,
   input  logic                       isActivated,
   input  logic                       byteValid,
   input  logic [7:0]                 byteData,
   output logic [3:0]                 fiCode,
   output logic [3:0]                 diCode,
   output logic [7:0]                 atrFiDi,
   output logic [3:0]                 atrK,
   output logic                       atrHasTck,
   output logic                       atrCompleted,
   output logic                       tckError,
   output logic                       ppsCompleted,
   output logic                       ppsAccepted,
   output logic                       ppsError,
   output logic                       waitCardTx,
   output logic                       waitTermTx,
   output logic [7:0]                 tpduIns,
   output logic [7:0]                 tpduP3,
   output logic [15:0]                sw,
   output logic                       swValid,
   output logic                       protocolError,
   output logic [BYTES_CNT_WIDTH-1:0] bytesCnt
);

   typedef enum logic [3:0] {
      ATR_TS, ATR_T0, ATR_IF, ATR_HIST, ATR_TCK, IDLE, PPS_REQ, PPS_RSP,
      HDR, PB, DATA, NACK, SW2
   } state_t;

   typedef struct packed {
      state_t          st;
      logic [3:0]      fi;
      logic [3:0]      di;
      logic [7:0]      atrFiDi;
      logic [3:0]      atrK;
      logic            hasTck;
      logic            atrDone;
      logic            tckErr;
      logic            ppsDone;
      logic            ppsAcc;
      logic            ppsErr;
      logic [1:0]      waitTx;
      logic [7:0]      ins;
      logic [7:0]      p3;
      logic [7:0]      sw1;
      logic [15:0]     sw;
      logic            swValid;
      logic            protoErr;
      logic [3:0]      ifMask;
      logic            firstGroup;
      logic [3:0]      histRem;
      logic [7:0]      xorAcc;
      logic            ppsAllowed;
      logic [5:0][7:0] ppsReq;
      logic [2:0]      ppsIdx;
      logic [2:0]      reqLen;
      logic [2:0]      rspLen;
      logic            reqPckOk;
      logic            rspMatch;
      logic [1:0]      hdrIdx;
      logic [8:0]      remain;
   } trk_t;

   trk_t r, n;

   function automatic trk_t resetVal();
      trk_t t;
      t         = '0;
      t.st      = ATR_TS;
      t.fi      = 4'd1;
      t.di      = 4'd1;
      t.atrFiDi = 8'h11;
      return t;
   endfunction

   function automatic trk_t atrComplete(input trk_t t);
      trk_t o;
      o            = t;
      o.atrDone    = 1'b1;
      o.st         = IDLE;
      o.waitTx     = 2'b01;
      o.ppsAllowed = 1'b1;
      return o;
   endfunction

   // hasTck in t must already include the byte just consumed
   function automatic trk_t atrAfterIf(input trk_t t);
      trk_t o;
      o = t;
      if (t.atrK != 4'd0) begin
         o.st      = ATR_HIST;
         o.histRem = t.atrK;
      end else if (t.hasTck) begin
         o.st = ATR_TCK;
      end else begin
         o = atrComplete(t);
      end
      return o;
   endfunction

   function automatic logic [2:0] ppsLen(input logic [7:0] pps0);
      return 3'd3 + 3'(pps0[4]) + 3'(pps0[5]) + 3'(pps0[6]);
   endfunction

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) r <= resetVal();
      else         r <= n;
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset)        bytesCnt <= '0;
      else if (byteValid) bytesCnt <= bytesCnt + 1'b1;
   end

   always_comb begin
      n         = r;
      n.swValid = 1'b0;
      if (!isActivated) begin
         n = resetVal();
      end else begin
         if (r.st == ATR_TS || r.st == ATR_T0 || r.st == ATR_IF ||
             r.st == ATR_HIST || r.st == ATR_TCK)
            n.waitTx = 2'b10;
         if (byteValid) begin
            case (r.st)
               ATR_TS: begin
                  n.st     = ATR_T0;
                  n.xorAcc = 8'h00;
               end
               ATR_T0: begin
                  n.xorAcc     = byteData;
                  n.atrK       = byteData[3:0];
                  n.ifMask     = byteData[7:4];
                  n.firstGroup = 1'b1;
                  if (byteData[7:4] == 4'd0) n = atrAfterIf(n);
                  else                       n.st = ATR_IF;
               end
               ATR_IF: begin
                  n.xorAcc = r.xorAcc ^ byteData;
                  // interface bytes arrive in TA, TB, TC, TD order
                  if (r.ifMask[0]) begin
                     n.ifMask[0] = 1'b0;
                     if (r.firstGroup) n.atrFiDi = byteData;
                  end else if (r.ifMask[1]) begin
                     n.ifMask[1] = 1'b0;
                  end else if (r.ifMask[2]) begin
                     n.ifMask[2] = 1'b0;
                  end else begin
                     n.ifMask     = byteData[7:4];
                     n.firstGroup = 1'b0;
                     if (byteData[3:0] != 4'd0) n.hasTck = 1'b1;
                  end
                  if (n.ifMask == 4'd0) n = atrAfterIf(n);
               end
               ATR_HIST: begin
                  n.xorAcc  = r.xorAcc ^ byteData;
                  n.histRem = r.histRem - 4'd1;
                  if (r.histRem == 4'd1) begin
                     if (r.hasTck) n.st = ATR_TCK;
                     else          n = atrComplete(n);
                  end
               end
               ATR_TCK: begin
                  n.xorAcc = r.xorAcc ^ byteData;
                  if (CHECK_TCK && ((r.xorAcc ^ byteData) != 8'h00)) n.tckErr = 1'b1;
                  n = atrComplete(n);
               end
               IDLE: begin
                  n.ppsAllowed = 1'b0;
                  if (byteData == 8'hFF && r.ppsAllowed) begin
                     n.st        = PPS_REQ;
                     n.ppsReq[0] = byteData;
                     n.ppsIdx    = 3'd1;
                     n.xorAcc    = byteData;
                  end else begin
                     if (byteData == 8'hFF) n.protoErr = 1'b1;
                     n.st     = HDR;
                     n.hdrIdx = 2'd0;
                  end
               end
               PPS_REQ: begin
                  n.ppsReq[r.ppsIdx] = byteData;
                  n.xorAcc           = r.xorAcc ^ byteData;
                  n.ppsIdx           = r.ppsIdx + 3'd1;
                  if (r.ppsIdx == 3'd1) n.reqLen = ppsLen(byteData);
                  if (r.ppsIdx >= 3'd2 && r.ppsIdx == r.reqLen - 3'd1) begin
                     n.reqPckOk = ((r.xorAcc ^ byteData) == 8'h00);
                     if ((r.xorAcc ^ byteData) != 8'h00) n.ppsErr = 1'b1;
                     n.st       = PPS_RSP;
                     n.ppsIdx   = 3'd0;
                     n.xorAcc   = 8'h00;
                     n.rspMatch = 1'b1;
                     n.waitTx   = 2'b10;
                  end
               end
               PPS_RSP: begin
                  n.xorAcc = r.xorAcc ^ byteData;
                  n.ppsIdx = r.ppsIdx + 3'd1;
                  if (byteData != r.ppsReq[r.ppsIdx]) n.rspMatch = 1'b0;
                  if (r.ppsIdx == 3'd1) n.rspLen = ppsLen(byteData);
                  if (r.ppsIdx >= 3'd2 && r.ppsIdx == r.rspLen - 3'd1) begin
                     n.ppsDone = 1'b1;
                     if ((r.xorAcc ^ byteData) != 8'h00) n.ppsErr = 1'b1;
                     n.ppsAcc = r.reqPckOk && ((r.xorAcc ^ byteData) == 8'h00) &&
                                n.rspMatch && (r.rspLen == r.reqLen);
                     if (n.ppsAcc && r.ppsReq[1][4]) {n.fi, n.di} = r.ppsReq[2];
                     n.st     = IDLE;
                     n.waitTx = 2'b01;
                  end
               end
               HDR: begin
                  n.hdrIdx = r.hdrIdx + 2'd1;
                  if (r.hdrIdx == 2'd0) n.ins = byteData;
                  if (r.hdrIdx == 2'd3) begin
                     n.p3     = byteData;
                     n.remain = (byteData == 8'h00) ? (P3_ZERO_IS_256 ? 9'd256 : 9'd0)
                                                    : {1'b0, byteData};
                     n.st     = PB;
                     n.waitTx = 2'b10;
                  end
               end
               PB: begin
                  if (byteData == 8'h60) begin
                     n.st = PB;
                  end else if (byteData[7:4] == 4'h6 || byteData[7:4] == 4'h9) begin
                     n.sw1 = byteData;
                     n.st  = SW2;
                  end else if (byteData == r.ins || byteData == ~r.ins) begin
                     if (r.remain == 9'd0) begin
                        n.protoErr = 1'b1;
                     end else begin
                        n.st     = (byteData == r.ins) ? DATA : NACK;
                        n.waitTx = 2'b11;
                     end
                  end else begin
                     n.protoErr = 1'b1;
                     n.st       = IDLE;
                     n.waitTx   = 2'b01;
                  end
               end
               DATA: begin
                  n.remain = r.remain - 9'd1;
                  if (r.remain == 9'd1) begin
                     n.st     = PB;
                     n.waitTx = 2'b10;
                  end
               end
               NACK: begin
                  n.remain = r.remain - 9'd1;
                  n.st     = PB;
                  n.waitTx = 2'b10;
               end
               SW2: begin
                  n.sw      = {r.sw1, byteData};
                  n.swValid = 1'b1;
                  n.st      = IDLE;
                  n.waitTx  = 2'b01;
               end
               default: n.st = ATR_TS;
            endcase
         end
      end
   end

   assign fiCode        = r.fi;
   assign diCode        = r.di;
   assign atrFiDi       = r.atrFiDi;
   assign atrK          = r.atrK;
   assign atrHasTck     = r.hasTck;
   assign atrCompleted  = r.atrDone;
   assign tckError      = r.tckErr;
   assign ppsCompleted  = r.ppsDone;
   assign ppsAccepted   = r.ppsAcc;
   assign ppsError      = r.ppsErr;
   assign waitCardTx    = r.waitTx[1];
   assign waitTermTx    = r.waitTx[0];
   assign tpduIns       = r.ins;
   assign tpduP3        = r.p3;
   assign sw            = r.sw;
   assign swValid       = r.swValid;
   assign protocolError = r.protoErr;

endmodule

// File: tb/tb_iso7816_3_tpdu_tracker.sv
// Directed bench for iso7816_3_tpdu_tracker: each sent byte may queue expected
// output values; a monitor pops and compares them in the cycle after the strobe.
module tb_iso7816_3_tpdu_tracker;

   logic        clk, nReset, isActivated, byteValid;
   logic [7:0]  byteData;
   logic [3:0]  fiCode, diCode, atrK;
   logic [7:0]  atrFiDi, tpduIns, tpduP3;
   logic        atrHasTck, atrCompleted, tckError;
   logic        ppsCompleted, ppsAccepted, ppsError;
   logic        waitCardTx, waitTermTx, swValid, protocolError;
   logic [15:0] sw;
   logic [31:0] bytesCnt;

   iso7816_3_tpdu_tracker dut (
      .clk(clk), .nReset(nReset), .isActivated(isActivated),
      .byteValid(byteValid), .byteData(byteData),
      .fiCode(fiCode), .diCode(diCode), .atrFiDi(atrFiDi), .atrK(atrK),
      .atrHasTck(atrHasTck), .atrCompleted(atrCompleted), .tckError(tckError),
      .ppsCompleted(ppsCompleted), .ppsAccepted(ppsAccepted), .ppsError(ppsError),
      .waitCardTx(waitCardTx), .waitTermTx(waitTermTx),
      .tpduIns(tpduIns), .tpduP3(tpduP3), .sw(sw), .swValid(swValid),
      .protocolError(protocolError), .bytesCnt(bytesCnt)
   );

   localparam int F_WAIT = 0, F_ATRDONE = 1, F_ATRK = 2, F_HASTCK = 3, F_TCKERR = 4,
                  F_FIDI = 5, F_PPSDONE = 6, F_PPSACC = 7, F_PPSERR = 8, F_FI = 9,
                  F_DI = 10, F_INS = 11, F_P3 = 12, F_SW = 13, F_SWV = 14,
                  F_PERR = 15, F_CNT = 16;

   typedef struct {
      int          seq;
      int          fid;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t sbq[$];
   int checks = 0, failures = 0, issued = 0, observed = 0, swPulses = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] getField(input int fid);
      case (fid)
         F_WAIT:    return {30'd0, waitCardTx, waitTermTx};
         F_ATRDONE: return {31'd0, atrCompleted};
         F_ATRK:    return {28'd0, atrK};
         F_HASTCK:  return {31'd0, atrHasTck};
         F_TCKERR:  return {31'd0, tckError};
         F_FIDI:    return {24'd0, atrFiDi};
         F_PPSDONE: return {31'd0, ppsCompleted};
         F_PPSACC:  return {31'd0, ppsAccepted};
         F_PPSERR:  return {31'd0, ppsError};
         F_FI:      return {28'd0, fiCode};
         F_DI:      return {28'd0, diCode};
         F_INS:     return {24'd0, tpduIns};
         F_P3:      return {24'd0, tpduP3};
         F_SW:      return {16'd0, sw};
         F_SWV:     return {31'd0, swValid};
         F_PERR:    return {31'd0, protocolError};
         default:   return bytesCnt;
      endcase
   endfunction

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endfunction

   function automatic void expectNext(input int fid, input logic [31:0] val, input string name);
      exp_t e;
      e.seq  = issued + 1;
      e.fid  = fid;
      e.val  = val;
      e.name = name;
      sbq.push_back(e);
   endfunction

   task automatic sendByte(input logic [7:0] b);
      issued++;
      byteData  = b;
      byteValid = 1'b1;
      @(posedge clk);
      #1;
      byteValid = 1'b0;
   endtask

   task automatic restart();
      isActivated = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("inactive_wait", {30'd0, waitCardTx, waitTermTx}, 32'd0);
      chk("inactive_atrDone", {31'd0, atrCompleted}, 32'd0);
      chk("inactive_tckErr", {31'd0, tckError}, 32'd0);
      chk("inactive_fidi", {24'd0, atrFiDi}, 32'h11);
      chk("inactive_fi", {28'd0, fiCode}, 32'd1);
      chk("inactive_ppsAcc", {31'd0, ppsAccepted}, 32'd0);
      isActivated = 1'b1;
      @(posedge clk); #1;
   endtask

   // monitor: compares queued expectations in the cycle after each strobe
   initial begin
      logic strobed;
      exp_t e;
      forever begin
         @(posedge clk);
         strobed = byteValid;
         @(negedge clk);
         if (swValid) swPulses++;
         if (strobed) begin
            observed++;
            while (sbq.size() > 0 && sbq[0].seq == observed) begin
               e = sbq.pop_front();
               chk(e.name, getField(e.fid), e.val);
            end
         end
      end
   end

   initial begin
      nReset = 1'b1; isActivated = 1'b0; byteValid = 1'b0; byteData = 8'h00;
      #2 nReset = 1'b0;
      #2;
      chk("rst_wait", {30'd0, waitCardTx, waitTermTx}, 32'd0);
      chk("rst_fi", {28'd0, fiCode}, 32'd1);
      chk("rst_di", {28'd0, diCode}, 32'd1);
      chk("rst_fidi", {24'd0, atrFiDi}, 32'h11);
      chk("rst_cnt", bytesCnt, 32'd0);
      chk("rst_atrDone", {31'd0, atrCompleted}, 32'd0);
      chk("rst_sw", {16'd0, sw}, 32'd0);
      chk("rst_ins", {24'd0, tpduIns}, 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      nReset = 1'b1; isActivated = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("act_wait", {30'd0, waitCardTx, waitTermTx}, 32'd2);

      // minimal ATR 3B 00
      expectNext(F_WAIT, 2, "ts_wait"); expectNext(F_ATRDONE, 0, "ts_atrDone");
      sendByte(8'h3B);
      expectNext(F_ATRDONE, 1, "a35_atrDone"); expectNext(F_ATRK, 0, "a35_atrK");
      expectNext(F_WAIT, 1, "a35_wait"); expectNext(F_CNT, 2, "a35_cnt");
      sendByte(8'h00);

      // TD1 announcing T=1 -> TCK required, good checksum
      restart();
      sendByte(8'h3B); sendByte(8'h80);
      expectNext(F_HASTCK, 1, "b1_hasTck"); expectNext(F_ATRDONE, 0, "b1_preTckDone");
      expectNext(F_WAIT, 2, "b1_preTckWait");
      sendByte(8'h01);
      expectNext(F_ATRDONE, 1, "b1_atrDone"); expectNext(F_TCKERR, 0, "b1_tckErr");
      expectNext(F_WAIT, 1, "b1_wait"); expectNext(F_CNT, 6, "b1_cnt");
      sendByte(8'h81);

      // same ATR with a bad TCK
      restart();
      sendByte(8'h3B); sendByte(8'h80); sendByte(8'h01);
      expectNext(F_TCKERR, 1, "b2_tckErr"); expectNext(F_ATRDONE, 1, "b2_atrDone");
      sendByte(8'h80);

      // TA1 = 96, PPS accepted
      restart();
      sendByte(8'h3B); sendByte(8'h10);
      expectNext(F_FIDI, 32'h96, "c1_fidi"); expectNext(F_ATRDONE, 1, "c1_atrDone");
      expectNext(F_WAIT, 1, "c1_wait");
      sendByte(8'h96);
      sendByte(8'hFF); sendByte(8'h10); sendByte(8'h96);
      expectNext(F_WAIT, 2, "c1_reqWait"); expectNext(F_PPSDONE, 0, "c1_reqDone");
      sendByte(8'h79);
      sendByte(8'hFF); sendByte(8'h10); sendByte(8'h96);
      expectNext(F_PPSDONE, 1, "c1_ppsDone"); expectNext(F_PPSACC, 1, "c1_ppsAcc");
      expectNext(F_PPSERR, 0, "c1_ppsErr"); expectNext(F_FI, 9, "c1_fi");
      expectNext(F_DI, 6, "c1_di"); expectNext(F_WAIT, 1, "c1_rspWait");
      sendByte(8'h79);

      // PPS answered with a different (shorter) response -> rejected
      restart();
      sendByte(8'h3B); sendByte(8'h10); sendByte(8'h96);
      sendByte(8'hFF); sendByte(8'h10); sendByte(8'h96); sendByte(8'h79);
      sendByte(8'hFF); sendByte(8'h00);
      expectNext(F_PPSDONE, 1, "c2_ppsDone"); expectNext(F_PPSACC, 0, "c2_ppsAcc");
      expectNext(F_PPSERR, 0, "c2_ppsErr"); expectNext(F_FI, 1, "c2_fi");
      expectNext(F_DI, 1, "c2_di"); expectNext(F_WAIT, 1, "c2_wait");
      sendByte(8'hFF);

      // SELECT with ACK and 2 data bytes, SW 9000
      sendByte(8'h00);
      expectNext(F_INS, 32'hA4, "s_ins");
      sendByte(8'hA4); sendByte(8'h04); sendByte(8'h00);
      expectNext(F_P3, 2, "s_p3"); expectNext(F_WAIT, 2, "s_hdrWait");
      sendByte(8'h02);
      expectNext(F_WAIT, 3, "s_ackWait"); sendByte(8'hA4);
      expectNext(F_WAIT, 3, "s_data1Wait"); sendByte(8'h3F);
      expectNext(F_WAIT, 2, "s_data2Wait"); sendByte(8'h00);
      expectNext(F_WAIT, 2, "s_sw1Wait"); expectNext(F_SWV, 0, "s_sw1Valid");
      sendByte(8'h90);
      expectNext(F_SW, 32'h9000, "s_sw"); expectNext(F_SWV, 1, "s_swValid");
      expectNext(F_WAIT, 1, "s_idleWait"); expectNext(F_PERR, 0, "s_perr");
      sendByte(8'h00);

      // UPDATE with two NACK bytes, SW 6110
      sendByte(8'h00);
      expectNext(F_INS, 32'hD6, "n_ins");
      sendByte(8'hD6); sendByte(8'h00); sendByte(8'h00); sendByte(8'h02);
      expectNext(F_WAIT, 3, "n_nack1Wait"); sendByte(8'h29);
      expectNext(F_WAIT, 2, "n_byte1Wait"); sendByte(8'h55);
      expectNext(F_WAIT, 3, "n_nack2Wait"); sendByte(8'h29);
      expectNext(F_WAIT, 2, "n_byte2Wait"); sendByte(8'h66);
      expectNext(F_SW, 32'h9000, "n_swHold"); expectNext(F_SWV, 0, "n_sw1Valid");
      sendByte(8'h61);
      expectNext(F_SW, 32'h6110, "n_sw"); expectNext(F_SWV, 1, "n_swValid");
      expectNext(F_WAIT, 1, "n_idleWait");
      sendByte(8'h10);

      // late PPSS is a protocol error and acts as CLA; P3=00 means 256 bytes
      expectNext(F_PERR, 1, "late_pps_perr"); sendByte(8'hFF);
      sendByte(8'hD6); sendByte(8'h00); sendByte(8'h00);
      expectNext(F_P3, 0, "z_p3"); expectNext(F_WAIT, 2, "z_hdrWait");
      sendByte(8'h00);
      expectNext(F_WAIT, 3, "z_ackWait"); sendByte(8'hD6);
      for (int i = 0; i < 255; i++) begin
         if (i == 254) expectNext(F_WAIT, 3, "z_byte255Wait");
         sendByte(8'hA5);
      end
      expectNext(F_WAIT, 2, "z_byte256Wait"); expectNext(F_CNT, issued + 1, "z_cnt");
      sendByte(8'hA5);
      sendByte(8'h90);
      expectNext(F_SWV, 1, "z_swValid"); sendByte(8'h00);

      // deactivation in the middle of DATA, strobe in the falling cycle not parsed
      sendByte(8'h00); sendByte(8'hB0); sendByte(8'h00); sendByte(8'h00); sendByte(8'h05);
      expectNext(F_WAIT, 3, "d_ackWait"); sendByte(8'hB0);
      expectNext(F_WAIT, 3, "d_dataWait"); sendByte(8'h22);
      isActivated = 1'b0;
      expectNext(F_WAIT, 0, "d_offWait"); expectNext(F_ATRDONE, 0, "d_offDone");
      expectNext(F_PERR, 0, "d_offPerr"); expectNext(F_SW, 0, "d_offSw");
      expectNext(F_CNT, issued + 1, "d_offCnt");
      sendByte(8'h3B);
      isActivated = 1'b1;
      expectNext(F_WAIT, 2, "d_tsWait"); expectNext(F_ATRDONE, 0, "d_tsDone");
      sendByte(8'h3B);
      expectNext(F_ATRDONE, 1, "d_atrDone"); expectNext(F_WAIT, 1, "d_wait");
      expectNext(F_CNT, issued + 1, "d_cnt");
      sendByte(8'h00);

      // ACK with nothing remaining, then an illegal procedure byte
      sendByte(8'h00); sendByte(8'hC0); sendByte(8'h00); sendByte(8'h00); sendByte(8'h01);
      expectNext(F_WAIT, 3, "e_ackWait"); sendByte(8'hC0);
      expectNext(F_WAIT, 2, "e_dataWait"); expectNext(F_PERR, 0, "e_prePerr");
      sendByte(8'h12);
      expectNext(F_PERR, 1, "e_ack0Perr"); expectNext(F_WAIT, 2, "e_ack0Wait");
      sendByte(8'hC0);
      expectNext(F_PERR, 1, "e_badPbPerr"); expectNext(F_WAIT, 1, "e_badPbWait");
      sendByte(8'h42);

      repeat (2) @(posedge clk);
      for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
      chk("drain", sbq.size(), 32'd0);
      chk("swPulses", swPulses, 32'd3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/iso7816_3_tpdu_tracker.md
ISO7816_3_TPDU_TRACKER -- requirements
Module: iso7816_3_tpdu_tracker

Interface
REQ-001 SHALL have parameter BYTES_CNT_WIDTH, default 32: width of bytesCnt.
REQ-002 SHALL have parameter P3_ZERO_IS_256, default 1: 1 = header P3 of 0 means 256 data bytes; 0 = no data bytes.
REQ-003 SHALL have parameter CHECK_TCK, default 1: 1 = compute the TCK check; 0 = tckError held 0.
REQ-004 clk  in  1  single clock, all logic rising edge.
REQ-005 nReset  in  1  reset, asynchronous, active-low.
REQ-006 isActivated  in  1  card session active; low forces session restart.
REQ-007 byteValid  in  1  one-cycle strobe, byteData is a completed received byte.
REQ-008 byteData  in  8  received byte, already convention-corrected.
REQ-009 fiCode, diCode  out  4 each  negotiated Fi/Di codes.
REQ-010 atrFiDi  out  8  TA1 value captured from the ATR (0x11 if TA1 absent).
REQ-011 atrK  out  4  historical byte count; atrHasTck  out  1; atrCompleted  out  1; tckError  out  1.
REQ-012 ppsCompleted  out  1; ppsAccepted  out  1; ppsError  out  1 (PCK mismatch or length > 6).
REQ-013 waitCardTx, waitTermTx  out  1 each  expected sender: 10 = card, 01 = terminal, 11 = either, 00 = none.
REQ-014 tpduIns, tpduP3  out  8 each  current header INS and P3.
REQ-015 sw  out  16  last {SW1,SW2}; swValid  out  1  one-cycle pulse on SW2; protocolError  out  1  sticky.
REQ-016 bytesCnt  out  BYTES_CNT_WIDTH  count of byteValid strobes, wraps modulo 2^width.

Function
REQ-017 The FSM SHALL have states ATR_TS, ATR_T0, ATR_IF, ATR_HIST, ATR_TCK, IDLE, PPS_REQ, PPS_RSP, HDR, PB, DATA, NACK, SW2; all state advances occur only on byteValid.
REQ-018 While isActivated=0 the block SHALL hold ATR_TS with all outputs except bytesCnt at reset values, synchronously, one cycle after the fall; a byteValid in that cycle SHALL be counted but not parsed.
REQ-019 ATR_TS SHALL consume TS, then go to ATR_T0; waitCardTx/waitTermTx = 10 from activation until atrCompleted.
REQ-020 ATR_T0 SHALL latch atrK = byte[3:0] and the interface-byte presence mask = byte[7:4]; ATR_IF SHALL consume popcount(mask[2:0]) TAi/TBi/TCi bytes, then TDi if mask[3]=1.
REQ-021 TA1 SHALL be latched into atrFiDi; any TDi with byte[3:0] != 0 SHALL set atrHasTck.
REQ-022 After the last interface byte: go to ATR_HIST if atrK != 0, else ATR_TCK if atrHasTck, else atrCompleted=1 and go to IDLE (waitCardTx/waitTermTx = 01).
REQ-023 The running XOR SHALL cover T0 through TCK; in ATR_TCK, tckError SHALL be set if XOR != 0 (CHECK_TCK=1), then the block SHALL complete as in REQ-022.
REQ-024 In IDLE, byte 0xFF SHALL enter PPS_REQ; any other byte SHALL be taken as CLA and enter HDR.
REQ-025 PPS length SHALL be 3 + popcount(PPS0[6:4]) with PPSS in byte 1; request bytes SHALL be stored (max 6) and per-message XOR checked; after the request, PPS_RSP with waitCardTx/waitTermTx = 10.
REQ-026 On the last response byte: ppsCompleted=1; ppsAccepted=1 iff both PCKs are good and the response equals the request byte-for-byte; if accepted with PPS1 present, {fiCode,diCode} = PPS1; go to IDLE.
REQ-027 A PPS message is legal only as the first exchange after the ATR; 0xFF in IDLE at any later time SHALL set protocolError and be treated as CLA.
REQ-028 HDR SHALL collect INS, P1, P2, P3 (tpduIns/tpduP3 updated as received), then go to PB with 10; the remaining count (9 bits) SHALL be P3, or 256 when P3=0 and P3_ZERO_IS_256=1.
REQ-029 PB transitions:
- 0x60: stay in PB.
- 0x6X (X != 0) or 0x9X: latch SW1, go to SW2.
- byte == INS: go to DATA (11).
- byte == ~INS: go to NACK (11).
- any other byte: set protocolError, go to IDLE (01).
REQ-030 DATA SHALL decrement the remaining count per byte and return to PB (10) at 0. ACK or NACK with remaining=0 SHALL set protocolError and stay in PB.
REQ-031 NACK SHALL consume one byte, decrement the remaining count, and return to PB (10).
REQ-032 SW2 SHALL latch sw={SW1,byte}, pulse swValid, and go to IDLE (01).
REQ-033 Back-to-back byteValid on consecutive cycles SHALL each be processed; outputs update one cycle after the strobe.

Reset
REQ-034 nReset low SHALL asynchronously reset the block to:
- fiCode=1, diCode=1, atrFiDi=0x11
- all flags and counts 0, sw=0, tpduIns=0, tpduP3=0
- waitCardTx/waitTermTx = 00, state ATR_TS.

Verification
REQ-035 ATR 3B 00 -> atrCompleted=1 after the 2nd byte, atrK=0, waitTermTx=1, bytesCnt=2.
REQ-036 ATR 3B 80 01 81 -> atrHasTck=1, tckError=0; with last byte 80 instead -> tckError=1.
REQ-037 ATR 3B 10 96, then PPS FF 10 96 79 and echo FF 10 96 79 -> ppsAccepted=1, fiCode=9, diCode=6; echo FF 00 FF -> ppsAccepted=0, codes stay 1/1.
REQ-038 Header 00 A4 04 00 02, then A4, 3F, 00, 90, 00 -> DATA consumes 2 bytes, back in PB, sw=0x9000, swValid pulses once, state IDLE.
REQ-039 Header 00 D6 00 00 02, then 29 xx 29 xx 61 10 -> two NACK bytes, sw=0x6110; header with P3=00 followed by D6 -> DATA expects 256 bytes.
REQ-040 isActivated falls mid-DATA, then returns with 3B 00 -> state restarts, atrCompleted=1, bytesCnt keeps counting.
